// File: rtl/bcd2bin_16_if.sv
// Conversion request/result bundle for bcd2bin_16: five BCD digits and start in,
// binary result, handshake and flags out.
interface bcd2bin_16_if;
  logic        start;
  logic [3:0]  BCD0;
  logic [3:0]  BCD1;
  logic [3:0]  BCD2;
  logic [3:0]  BCD3;
  logic [3:0]  BCD4;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic        err_digit;
  logic        ovf;

  modport master (
    output start, BCD0, BCD1, BCD2, BCD3, BCD4,
    input  bin, busy, done, err_digit, ovf
  );

  modport slave (
    input  start, BCD0, BCD1, BCD2, BCD3, BCD4,
    output bin, busy, done, err_digit, ovf
  );
endinterface

// File: rtl/bcd2bin_16.sv
// Sequential five-digit BCD to 16-bit binary converter, one digit per clock, MSD first.
// Optional macro BCD2BIN_SATURATE_EN: overflow or an illegal digit saturates bin to 16'hFFFF.
module bcd2bin_16 (
  input  logic          clk,
  input  logic          rst,
  bcd2bin_16_if.slave   bus
);

  localparam int NDIG  = 5;
  localparam int ACC_W = 18;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [2:0]         idx_q, idx_d;
  logic [3:0]         dig_q [NDIG];
  logic [3:0]         dig_d [NDIG];
  logic               err_w_q, err_w_d;
  logic [15:0]        bin_q, bin_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_digit_q, err_digit_d;
  logic               ovf_q, ovf_d;

  logic [3:0]         cur_dig_s;
  logic [ACC_W-1:0]   acc_step_s;
  logic               step_err_s;
  logic               step_ovf_s;

  function automatic logic [3:0] sel_digit(input logic [2:0] idx,
                                           input logic [3:0] d0,
                                           input logic [3:0] d1,
                                           input logic [3:0] d2,
                                           input logic [3:0] d3,
                                           input logic [3:0] d4);
    logic [3:0] r;
    case (idx)
      3'd0:    r = d0;
      3'd1:    r = d1;
      3'd2:    r = d2;
      3'd3:    r = d3;
      3'd4:    r = d4;
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  assign cur_dig_s  = sel_digit(idx_q, dig_q[0], dig_q[1], dig_q[2], dig_q[3], dig_q[4]);
  // acc*10 as (acc<<3)+(acc<<1); the raw digit is added even when illegal
  assign acc_step_s = {acc_q[ACC_W-4:0], 3'b000} + {acc_q[ACC_W-2:0], 1'b0}
                    + {{(ACC_W-4){1'b0}}, cur_dig_s};
  assign step_err_s = err_w_q | (cur_dig_s > 4'd9);
  assign step_ovf_s = |acc_step_s[ACC_W-1:16];

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    dig_d       = dig_q;
    err_w_d     = err_w_q;
    bin_d       = bin_q;
    err_digit_d = err_digit_q;
    ovf_d       = ovf_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          dig_d[0] = bus.BCD0;
          dig_d[1] = bus.BCD1;
          dig_d[2] = bus.BCD2;
          dig_d[3] = bus.BCD3;
          dig_d[4] = bus.BCD4;
          acc_d    = {ACC_W{1'b0}};
          idx_d    = 3'd4;
          err_w_d  = 1'b0;
          busy_d   = 1'b1;
          state_d  = S_CONV;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_CONV: begin
        acc_d   = acc_step_s;
        err_w_d = step_err_s;
        busy_d  = 1'b1;
        if (idx_q == 3'd0) begin
          state_d     = S_DONE;
          done_d      = 1'b1;
          ovf_d       = step_ovf_s;
          err_digit_d = step_err_s;
`ifdef BCD2BIN_SATURATE_EN
          if (step_ovf_s || step_err_s) begin
            bin_d = 16'hFFFF;
          end else begin
            bin_d = acc_step_s[15:0];
          end
`else
          bin_d = acc_step_s[15:0];
`endif
        end else begin
          idx_d   = idx_q - 3'd1;
          state_d = S_CONV;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= {ACC_W{1'b0}};
      idx_q       <= 3'd0;
      for (int i = 0; i < NDIG; i++) begin
        dig_q[i]  <= 4'd0;
      end
      err_w_q     <= 1'b0;
      bin_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_digit_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      for (int i = 0; i < NDIG; i++) begin
        dig_q[i]  <= dig_d[i];
      end
      err_w_q     <= err_w_d;
      bin_q       <= bin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_digit_q <= err_digit_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.bin       = bin_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err_digit = err_digit_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bcd2bin_16.sv
// Directed self-checking bench for bcd2bin_16 with hand-computed expected values.
module tb_bcd2bin_16;

  logic clk;
  logic rst;
  int   tests_run;
  int   fails;

  bcd2bin_16_if u_if ();

  bcd2bin_16 dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

`ifdef BCD2BIN_SATURATE_EN
  localparam logic [15:0] EXP_65536 = 16'hFFFF;
  localparam logic [15:0] EXP_99999 = 16'hFFFF;
  localparam logic [15:0] EXP_ERRA  = 16'hFFFF;
`else
  localparam logic [15:0] EXP_65536 = 16'd0;
  localparam logic [15:0] EXP_99999 = 16'd34463;
  localparam logic [15:0] EXP_ERRA  = 16'd1000;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_digits(input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                            input logic [3:0] d1, input logic [3:0] d0);
    u_if.BCD4 = d4;
    u_if.BCD3 = d3;
    u_if.BCD2 = d2;
    u_if.BCD1 = d1;
    u_if.BCD0 = d0;
  endtask

  // One conversion: checks done position, single pulse, busy length and results.
  // Inputs are scrambled after the latch edge; optionally start is re-pulsed mid-conversion.
  task automatic run_conv(input string tag,
                          input logic [3:0] d4, input logic [3:0] d3, input logic [3:0] d2,
                          input logic [3:0] d1, input logic [3:0] d0,
                          input logic [15:0] exp_bin, input logic exp_err, input logic exp_ovf,
                          input bit repulse);
    int done_at;
    int done_cnt;
    int busy_cnt;
    @(posedge clk); #1;
    set_digits(d4, d3, d2, d1, d0);
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    set_digits(4'h8, 4'h8, 4'h8, 4'h8, 4'h8);
    done_at  = 0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (u_if.done) begin
        done_cnt++;
        done_at = k;
      end
      if (u_if.busy) busy_cnt++;
      if (repulse && k == 2) u_if.start = 1'b1;
      if (repulse && k == 3) u_if.start = 1'b0;
    end
    check({tag, ".done_at"},  done_at,  6);
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".busy_cnt"}, busy_cnt, 6);
    check({tag, ".bin"},      {16'd0, u_if.bin}, {16'd0, exp_bin});
    check({tag, ".err"},      {31'd0, u_if.err_digit}, {31'd0, exp_err});
    check({tag, ".ovf"},      {31'd0, u_if.ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    int first_done;
    int second_done;
    int done_cnt;
    tests_run = 0;
    fails     = 0;
    rst       = 1'b1;
    u_if.start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.bin",  {16'd0, u_if.bin}, 32'd0);
    check("reset.busy", {31'd0, u_if.busy}, 32'd0);
    check("reset.done", {31'd0, u_if.done}, 32'd0);
    check("reset.err",  {31'd0, u_if.err_digit}, 32'd0);
    check("reset.ovf",  {31'd0, u_if.ovf}, 32'd0);
    rst = 1'b0;

    run_conv("c1234",  4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 16'd1234,  1'b0, 1'b0, 1'b0);
    run_conv("c0",     4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 16'd0,     1'b0, 1'b0, 1'b0);
    run_conv("c65535", 4'd6, 4'd5, 4'd5, 4'd3, 4'd5, 16'd65535, 1'b0, 1'b0, 1'b0);
    run_conv("c65536", 4'd6, 4'd5, 4'd5, 4'd3, 4'd6, EXP_65536, 1'b0, 1'b1, 1'b0);
    run_conv("cerrA",  4'd0, 4'd0, 4'hA, 4'd0, 4'd0, EXP_ERRA,  1'b1, 1'b0, 1'b0);
    run_conv("c99999", 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, EXP_99999, 1'b0, 1'b1, 1'b0);

    // Outputs hold between done pulses.
    repeat (3) @(negedge clk);
    check("hold.bin", {16'd0, u_if.bin}, {16'd0, EXP_99999});
    check("hold.ovf", {31'd0, u_if.ovf}, 32'd1);

    // Reset three cycles into a conversion.
    @(posedge clk); #1;
    set_digits(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
    u_if.start = 1'b1;
    @(posedge clk); #1;
    u_if.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst.bin",  {16'd0, u_if.bin}, 32'd0);
    check("midrst.busy", {31'd0, u_if.busy}, 32'd0);
    check("midrst.ovf",  {31'd0, u_if.ovf}, 32'd0);
    check("midrst.err",  {31'd0, u_if.err_digit}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (u_if.done) done_cnt++;
    end
    check("midrst.nodone", done_cnt, 0);
    run_conv("c7", 4'd0, 4'd0, 4'd0, 4'd0, 4'd7, 16'd7, 1'b0, 1'b0, 1'b0);

    // start re-pulsed while busy with changed inputs is ignored.
    run_conv("repulse", 4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 16'd4321, 1'b0, 1'b0, 1'b1);

    // Held start: back-to-back conversions seven cycles apart.
    @(posedge clk); #1;
    set_digits(4'd0, 4'd0, 4'd0, 4'd4, 4'd2);
    u_if.start  = 1'b1;
    first_done  = -1;
    second_done = -1;
    for (int k = 0; k < 20 && second_done < 0; k++) begin
      @(negedge clk);
      if (u_if.done) begin
        if (first_done < 0) first_done = k;
        else second_done = k;
      end
    end
    u_if.start = 1'b0;
    check("held.second_seen", {31'd0, second_done >= 0}, 32'd1);
    check("held.period", second_done - first_done, 7);
    check("held.bin", {16'd0, u_if.bin}, 32'd42);
    repeat (10) @(negedge clk);
    check("held.idle_busy", {31'd0, u_if.busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
